// File: rtl/writeback_selector.sv
// Writeback selector: routes ALU, PC+4 or load data to the register-file write port.
// Loads wait in WAIT_MEM for mem_rvalid; define WB_TIMEOUT_EN to bound that wait (timeout_err).

module writeback_selector #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  wb_type,
   input  logic [31:0] alu_result,
   input  logic [31:0] pc,
   input  logic [2:0]  load_type,
   input  logic [4:0]  rd_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        reg_we,
   output logic [4:0]  reg_waddr,
   output logic [31:0] reg_wdata,
   output logic        misalign_err,
   output logic        timeout_err
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_NONE = 2'b11;

   localparam logic [2:0] LT_LB  = 3'b000;
   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LW  = 3'b010;
   localparam logic [2:0] LT_LBU = 3'b100;
   localparam logic [2:0] LT_LHU = 3'b101;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("writeback_selector: TIMEOUT_CYCLES must be within 1..255");
   end

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          off_q, off_d;
   logic [2:0]          lt_q, lt_d;
   logic [REG_AW-1:0]   rd_q, rd_d;
   logic                reg_we_q, reg_we_d;
   logic [REG_AW-1:0]   reg_waddr_q, reg_waddr_d;
   logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
   logic                misalign_q, misalign_d;

`ifdef WB_TIMEOUT_EN
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                timeout_q, timeout_d;
`endif

   logic                misaligned_c;
   logic [7:0]          byte_c;
   logic [15:0]         half_c;
   logic [DATA_W-1:0]   load_data_c;

   // Alignment of an incoming load: halfwords need even offsets, words (and reserved codes) offset 0
   always_comb begin
      misaligned_c = 1'b0;
      case (load_type)
         LT_LB, LT_LBU: misaligned_c = 1'b0;
         LT_LH, LT_LHU: misaligned_c = alu_result[0];
         LT_LW:         misaligned_c = |alu_result[1:0];
         default:       misaligned_c = |alu_result[1:0];
      endcase
   end

   // Lane selection and extension of the returned load word
   always_comb begin
      byte_c = 8'h00;
      case (off_q)
         2'd0:    byte_c = mem_rdata[7:0];
         2'd1:    byte_c = mem_rdata[15:8];
         2'd2:    byte_c = mem_rdata[23:16];
         default: byte_c = mem_rdata[31:24];
      endcase
      half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      load_data_c = mem_rdata;
      case (lt_q)
         LT_LB:   load_data_c = {{24{byte_c[7]}}, byte_c};
         LT_LBU:  load_data_c = {24'h000000, byte_c};
         LT_LH:   load_data_c = {{16{half_c[15]}}, half_c};
         LT_LHU:  load_data_c = {16'h0000, half_c};
         LT_LW:   load_data_c = mem_rdata;
         default: load_data_c = mem_rdata;
      endcase
   end

   assign in_ready = (state_q == IDLE);

   // Next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      lt_d        = lt_q;
      rd_d        = rd_q;
      reg_we_d    = 1'b0;
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;
      misalign_d  = 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_d       = cnt_q;
      timeout_d   = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               case (wb_type)
                  WB_ALU: begin
                     if (rd_addr != '0) begin
                        reg_we_d    = 1'b1;
                        reg_waddr_d = rd_addr;
                        reg_wdata_d = alu_result;
                     end
                  end
                  WB_PC4: begin
                     if (rd_addr != '0) begin
                        reg_we_d    = 1'b1;
                        reg_waddr_d = rd_addr;
                        reg_wdata_d = pc + 32'd4;
                     end
                  end
                  WB_MEM: begin
                     if (misaligned_c) begin
                        misalign_d = 1'b1;
                     end else begin
                        off_d   = alu_result[1:0];
                        lt_d    = load_type;
                        rd_d    = rd_addr;
                        state_d = WAIT_MEM;
`ifdef WB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                     end
                  end
                  WB_NONE: ;
                  default: ;
               endcase
            end
         end

         WAIT_MEM: begin
            if (mem_rvalid) begin
               state_d = IDLE;
               if (rd_q != '0) begin
                  reg_we_d    = 1'b1;
                  reg_waddr_d = rd_q;
                  reg_wdata_d = load_data_c;
               end
`ifdef WB_TIMEOUT_EN
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         off_q       <= '0;
         lt_q        <= '0;
         rd_q        <= '0;
         reg_we_q    <= 1'b0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         lt_q        <= lt_d;
         rd_q        <= rd_d;
         reg_we_q    <= reg_we_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
         misalign_q  <= misalign_d;
      end
   end

`ifdef WB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign reg_we       = reg_we_q;
   assign reg_waddr    = reg_waddr_q;
   assign reg_wdata    = reg_wdata_q;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_writeback_selector.sv
// Self-checking bench for writeback_selector: directed vector table, hand-written
// corner sequences (back-to-back, reset mid-load, timeout) and randomized transactions.

module tb_writeback_selector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  wb_type;
   logic [31:0] alu_result;
   logic [31:0] pc;
   logic [2:0]  load_type;
   logic [4:0]  rd_addr;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        reg_we;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic        misalign_err;
   logic        timeout_err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [4:0]  last_wa = '0;
   logic [31:0] last_wd = '0;

   typedef struct {
      logic [1:0]  wb;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [2:0]  lt;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          waitc;
      logic        exp_we;
      logic [31:0] exp_wd;
      logic        exp_mis;
   } vec_t;

   writeback_selector #(.TIMEOUT_CYCLES(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .wb_type      (wb_type),
      .alu_result   (alu_result),
      .pc           (pc),
      .load_type    (load_type),
      .rd_addr      (rd_addr),
      .mem_rdata    (mem_rdata),
      .mem_rvalid   (mem_rvalid),
      .reg_we       (reg_we),
      .reg_waddr    (reg_waddr),
      .reg_wdata    (reg_wdata),
      .misalign_err (misalign_err),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: a load of size N bytes is aligned iff offset % N == 0;
   // the selected lane is (word >> 8*off) mod 2^(8N), sign-adjusted for LB/LH.
   function automatic vec_t make_vec(input logic [1:0] wb, input logic [31:0] alu,
                                     input logic [31:0] pcv, input logic [2:0] lt,
                                     input logic [4:0] rd, input logic [31:0] rdata,
                                     input int waitc);
      vec_t v;
      int unsigned off, sz;
      longint x, span;
      v.wb = wb; v.alu = alu; v.pc = pcv; v.lt = lt; v.rd = rd; v.rdata = rdata; v.waitc = waitc;
      off = alu % 4;
      if (lt == 3'd0 || lt == 3'd4)      sz = 1;
      else if (lt == 3'd1 || lt == 3'd5) sz = 2;
      else                               sz = 4;
      v.exp_mis = (wb == 2'd1) && ((off % sz) != 0);
      span = longint'(1) << (8 * sz);
      x = (longint'(rdata) >> (8 * off)) % span;
      if ((lt == 3'd0 || lt == 3'd1) && x >= span / 2) x = x - span;
      case (wb)
         2'd0:    v.exp_wd = alu;
         2'd2:    v.exp_wd = pcv + 32'd4;
         2'd1:    v.exp_wd = 32'(x);
         default: v.exp_wd = 32'h0;
      endcase
      v.exp_we = (wb != 2'd3) && !v.exp_mis && (rd != 5'd0);
      return v;
   endfunction

   task automatic check_result(input string name, input vec_t v);
      chk($sformatf("%s reg_we", name), 32'(reg_we), 32'(v.exp_we));
      chk($sformatf("%s misalign_err", name), 32'(misalign_err), 32'(v.exp_mis));
      chk($sformatf("%s timeout_err", name), 32'(timeout_err), 32'h0);
      chk($sformatf("%s in_ready after", name), 32'(in_ready), 32'h1);
      if (v.exp_we) begin
         chk($sformatf("%s reg_waddr", name), 32'(reg_waddr), 32'(v.rd));
         chk($sformatf("%s reg_wdata", name), reg_wdata, v.exp_wd);
         last_wa = v.rd;
         last_wd = v.exp_wd;
      end else begin
         chk($sformatf("%s waddr hold", name), 32'(reg_waddr), 32'(last_wa));
         chk($sformatf("%s wdata hold", name), reg_wdata, last_wd);
      end
   endtask

   // One full transaction from IDLE; random mem_rvalid during accept must be ignored
   task automatic do_txn(input string name, input vec_t v);
      chk($sformatf("%s in_ready before", name), 32'(in_ready), 32'h1);
      in_valid   = 1'b1;
      wb_type    = v.wb;
      alu_result = v.alu;
      pc         = v.pc;
      load_type  = v.lt;
      rd_addr    = v.rd;
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      tick();
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      alu_result = $urandom;
      rd_addr    = 5'($urandom);
      load_type  = 3'($urandom);
      if (v.wb == 2'd1 && !v.exp_mis) begin
         chk($sformatf("%s in_ready in wait", name), 32'(in_ready), 32'h0);
         chk($sformatf("%s no early write", name), 32'(reg_we), 32'h0);
         repeat (v.waitc) tick();
         chk($sformatf("%s in_ready end of wait", name), 32'(in_ready), 32'h0);
         mem_rvalid = 1'b1;
         mem_rdata  = v.rdata;
         tick();
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
      end
      check_result(name, v);
      tick();
      chk($sformatf("%s reg_we pulse end", name), 32'(reg_we), 32'h0);
      chk($sformatf("%s misalign pulse end", name), 32'(misalign_err), 32'h0);
   endtask

   task automatic start_load(input logic [4:0] rd);
      in_valid   = 1'b1;
      wb_type    = 2'd1;
      alu_result = 32'h0000_0100;
      load_type  = 3'd2;
      rd_addr    = rd;
      mem_rvalid = 1'b0;
      tick();
      in_valid   = 1'b0;
   endtask

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{2'd0, 32'h12345678, 32'h0, 3'd0, 5'd5,  32'h0,        0, 1'b1, 32'h12345678, 1'b0};
      tbl[1]  = '{2'd1, 32'h00000003, 32'h0, 3'd0, 5'd7,  32'h80FF0011, 3, 1'b1, 32'hFFFFFF80, 1'b0};
      tbl[2]  = '{2'd1, 32'h00000003, 32'h0, 3'd4, 5'd7,  32'h80FF0011, 3, 1'b1, 32'h00000080, 1'b0};
      tbl[3]  = '{2'd1, 32'h00001001, 32'h0, 3'd1, 5'd9,  32'h0,        0, 1'b0, 32'h0,        1'b1};
      tbl[4]  = '{2'd1, 32'h00000002, 32'h0, 3'd5, 5'd10, 32'hBEEF0000, 1, 1'b1, 32'h0000BEEF, 1'b0};
      tbl[5]  = '{2'd1, 32'h00000000, 32'h0, 3'd2, 5'd0,  32'hDEADBEEF, 2, 1'b0, 32'h0,        1'b0};
      tbl[6]  = '{2'd3, 32'h55555555, 32'h0, 3'd0, 5'd9,  32'h0,        0, 1'b0, 32'h0,        1'b0};
      tbl[7]  = '{2'd2, 32'h0,  32'hFFFFFFFC, 3'd0, 5'd3,  32'h0,        0, 1'b1, 32'h00000000, 1'b0};
      tbl[8]  = '{2'd1, 32'h00000002, 32'h0, 3'd1, 5'd11, 32'h80010000, 0, 1'b1, 32'hFFFF8001, 1'b0};
      tbl[9]  = '{2'd1, 32'h00000000, 32'h0, 3'd3, 5'd12, 32'hCAFEF00D, 2, 1'b1, 32'hCAFEF00D, 1'b0};
      tbl[10] = '{2'd1, 32'h00000005, 32'h0, 3'd2, 5'd13, 32'h0,        0, 1'b0, 32'h0,        1'b1};
      tbl[11] = '{2'd0, 32'hA5A5A5A5, 32'h0, 3'd0, 5'd0,  32'h0,        0, 1'b0, 32'h0,        1'b0};
      tbl[12] = '{2'd1, 32'h00000001, 32'h0, 3'd0, 5'd14, 32'h00007F00, 0, 1'b1, 32'h0000007F, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; wb_type = '0; alu_result = '0; pc = '0;
      load_type = '0; rd_addr = '0; mem_rdata = '0; mem_rvalid = 1'b0;
      #2;
      chk("reset reg_we", 32'(reg_we), 32'h0);
      chk("reset reg_waddr", 32'(reg_waddr), 32'h0);
      chk("reset reg_wdata", reg_wdata, 32'h0);
      chk("reset misalign_err", 32'(misalign_err), 32'h0);
      chk("reset timeout_err", 32'(timeout_err), 32'h0);
      chk("reset in_ready", 32'(in_ready), 32'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 13; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

      // Back-to-back ALU then PC4 with in_valid held high
      in_valid = 1'b1; wb_type = 2'd0; rd_addr = 5'd5; alu_result = 32'h12345678;
      tick();
      chk("b2b first we", 32'(reg_we), 32'h1);
      chk("b2b first waddr", 32'(reg_waddr), 32'd5);
      chk("b2b first wdata", reg_wdata, 32'h12345678);
      chk("b2b in_ready", 32'(in_ready), 32'h1);
      wb_type = 2'd2; rd_addr = 5'd6; pc = 32'h100;
      tick();
      in_valid = 1'b0;
      chk("b2b second we", 32'(reg_we), 32'h1);
      chk("b2b second waddr", 32'(reg_waddr), 32'd6);
      chk("b2b second wdata", reg_wdata, 32'h104);
      chk("b2b in_ready 2", 32'(in_ready), 32'h1);
      last_wa = 5'd6; last_wd = 32'h104;
      tick();
      chk("b2b idle we", 32'(reg_we), 32'h0);

      // Reset while a load is pending: load abandoned, rvalid afterwards ignored
      start_load(5'd4);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rst mid-wait in_ready", 32'(in_ready), 32'h1);
      chk("rst mid-wait reg_we", 32'(reg_we), 32'h0);
      chk("rst mid-wait wdata", reg_wdata, 32'h0);
      chk("rst mid-wait waddr", 32'(reg_waddr), 32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post-rst no write", 32'(reg_we), 32'h0);
      chk("post-rst misalign", 32'(misalign_err), 32'h0);
      chk("post-rst timeout", 32'(timeout_err), 32'h0);
      chk("post-rst in_ready", 32'(in_ready), 32'h1);
      mem_rvalid = 1'b0;
      last_wa = '0; last_wd = '0;

`ifdef WB_TIMEOUT_EN
      start_load(5'd8);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk($sformatf("to wait%0d err", i), 32'(timeout_err), 32'h0);
         chk($sformatf("to wait%0d ready", i), 32'(in_ready), 32'h0);
      end
      tick();
      chk("timeout pulse", 32'(timeout_err), 32'h1);
      chk("timeout no write", 32'(reg_we), 32'h0);
      chk("timeout in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("timeout pulse end", 32'(timeout_err), 32'h0);

      start_load(5'd8);
      repeat (7) tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
      tick();
      mem_rvalid = 1'b0;
      chk("late rvalid we", 32'(reg_we), 32'h1);
      chk("late rvalid wdata", reg_wdata, 32'h0BADF00D);
      chk("late rvalid no timeout", 32'(timeout_err), 32'h0);
      last_wa = 5'd8; last_wd = 32'h0BADF00D;
      tick();
`else
      start_load(5'd8);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("long wait%0d ready", i), 32'(in_ready), 32'h0);
         chk($sformatf("long wait%0d err", i), 32'(timeout_err), 32'h0);
      end
      mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
      tick();
      mem_rvalid = 1'b0;
      chk("long wait we", 32'(reg_we), 32'h1);
      chk("long wait wdata", reg_wdata, 32'h0BADF00D);
      last_wa = 5'd8; last_wd = 32'h0BADF00D;
      tick();
`endif

      // Randomized transactions against the reference model
      for (int i = 0; i < 150; i++) begin
         logic [1:0]  wb;
         logic [4:0]  rd;
         vec_t        v;
         wb = 2'($urandom);
         rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         v  = make_vec(wb, $urandom, $urandom, 3'($urandom), rd, $urandom,
                       int'($urandom_range(0, 5)));
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            tick();
            chk($sformatf("rnd%0d idle we", i), 32'(reg_we), 32'h0);
         end
         do_txn($sformatf("rnd%0d", i), v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
